// File: rtl/rr_mux_if.sv
// rr_mux_if: valid/ready input channels and registered output of rr_mux_reg
interface rr_mux_if #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 2,
  parameter int SEL_W = $clog2(N_CH)
);
  logic                  mode;
  logic [SEL_W-1:0]      sel;
  logic [N_CH-1:0]       in_valid;
  logic [N_CH-1:0]       in_ready;
  logic [N_CH*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [SEL_W-1:0]      out_ch;
  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_mux_reg.sv
// rr_mux_reg: registered N-channel mux, fixed-select or round-robin, valid/ready on all sides
module rr_mux_reg #(
  parameter int WIDTH = 4,
  parameter int N_CH  = 2,
  parameter int SEL_W = $clog2(N_CH)
) (
  input logic     clk,
  input logic     rst,
  rr_mux_if.slave bus
);
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] idx, win;
  logic [WIDTH-1:0] mux_data;
  logic             found, load, xfer;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!bus.mode && bus.sel == SEL_W'(k)) grant[k] = bus.in_valid[k];
      idx = SEL_W'((int'(ptr_q) + k) % N_CH);
      if (bus.mode && !found && bus.in_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
  // AND-OR mux keeps X on ungranted channels away from the output register
  always_comb begin
    win      = '0;
    mux_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (grant[i]) win = SEL_W'(i);
      mux_data = mux_data | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end
  always_comb begin
    load        = !out_valid_q || bus.out_ready;
    bus.in_ready = grant & {N_CH{load && !rst}};
    xfer        = |bus.in_ready;
    out_valid_d = xfer || (out_valid_q && !bus.out_ready);
    out_data_d  = xfer ? mux_data : out_data_q;
    out_ch_d    = xfer ? win : out_ch_q;
    ptr_d       = (xfer && bus.mode) ? ((win == SEL_W'(N_CH - 1)) ? '0 : win + 1'b1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised, registered N-channel data multiplexer with a valid/ready handshake on every input and on the output.
- Next generation of the team's fixed 4-bit 2:1 select mux used in the carry-select datapath.
- Generalised in width and channel count.
- Two selection modes: fixed-select (external `sel`) and round-robin arbitration.
- One output register stage; sits between operand/result sources and the downstream ALU stage.

Parameters:
- WIDTH, 4, data width per channel in bits (≥1).
- N_CH, 2, number of input channels (2..16).
- SEL_W, $clog2(N_CH), width of the `sel` and `out_ch` fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = fixed-select by `sel`; 1 = round-robin.
- sel  input  SEL_W  channel index used when mode=0.
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  output register holds data.
- out_ready  input  1  downstream accepts.
- out_data  output  WIDTH  registered data.
- out_ch  output  SEL_W  index of the channel that produced out_data.

Behaviour:
- Reset (rst=1 at a rising edge): out_valid=0, out_data=0, out_ch=0, round-robin pointer ptr=0 (channel 0 has highest priority).
  - in_ready is all-zero while rst=1.
  - Reset mid-transfer discards the held word.
- Load condition: `load = !out_valid || out_ready`.
  - When the output register is full and downstream stalls, every in_ready is 0.
- Grant (combinational, one-hot or zero):
  - mode=0:
    - grant[sel] = in_valid[sel].
    - sel ≥ N_CH (possible when N_CH is not a power of 2) → no grant.
    - Other channels are never granted.
  - mode=1:
    - Scan channels ptr, ptr+1, … modulo N_CH.
    - Grant the first channel with in_valid=1.
    - No valid channel → no grant.
- Handshake:
  - in_ready[i] = grant[i] && load && !rst.
  - A transfer on channel i occurs when in_valid[i] && in_ready[i].
  - At most one input transfer per cycle.
- On a transfer from channel k at a clock edge:
  - out_data ← in_data[k]
  - out_ch ← k
  - out_valid ← 1
  - mode=1 only: ptr ← (k+1) mod N_CH.
  - mode=0 never changes ptr.
- No transfer at the edge:
  - If out_valid && out_ready: out_valid ← 0. out_data and out_ch keep their last values.
  - Otherwise all registers hold.
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 word/cycle when out_ready stays high. Simultaneous output drain and input load in the same cycle is required (back-to-back, no bubble).
- Output stability: while out_valid=1 and out_ready=0, out_data and out_ch must not change.
- Mode change takes effect on the next grant evaluation. A held output word is unaffected. ptr is retained across mode switches.
- Wrap-around: a grant to channel N_CH-1 sets ptr to 0.
- Input data on ungranted channels has no effect. X on them must not propagate to out_data.

Test Plan:
- Reset/idle (N_CH=4, WIDTH=4): assert rst for 2 cycles with all in_valid=1.
  - Required: in_ready=0000, out_valid=0, out_data=0, out_ch=0.
  - After release with mode=1: first transfer is from ch0.
- Fixed select: mode=0, sel=2, in_valid=1111, data ch0..3 = 1,5,A,F, out_ready=1.
  - Required: out_data=A and out_ch=2 one cycle later, every cycle.
  - in_ready=0100.
- Round-robin fairness: mode=1, all channels valid continuously, out_ready=1.
  - Required: out_ch sequence 0,1,2,3,0,1 on consecutive cycles.
  - out_valid=1 every cycle after the first.
- Sparse round-robin: mode=1, only ch1 and ch3 valid.
  - Required: out_ch alternates 1,3,1,3.
  - ptr wraps from 3→0 and ch1 is granted next.
- Backpressure: a word is held with out_ready=0 for 3 cycles while inputs stay valid.
  - Required: in_ready=0000, out_data/out_ch stable for all 3 cycles.
  - The next word appears the cycle after out_ready=1, with no bubble and no lost data.
- Illegal select and mid-stream reset: N_CH=3, mode=0, sel=3.
  - Required: no grant, out_valid stays 0.
  - Then rst pulsed while out_valid=1: out_valid=0 next cycle, ptr=0.
